// File: rtl/instruction_fetch_unit.sv
// RV32I fetch stage: owns the PC, issues in-order imem requests, buffers responses and drains stale ones after a redirect.
// Optional build macro FETCH_MISALIGN_TRAP_EN: misaligned redirect targets raise a sticky fetch_misaligned trap.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic [96:0] if_packet,
`ifdef FETCH_MISALIGN_TRAP_EN
  output logic        fetch_misaligned,
`endif
  output logic        if_valid
);

  localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
  localparam logic [CNT_W:0] CAP = (CNT_W + 1)'(BUF_DEPTH);

  typedef enum logic {RUN, DRAIN} state_e;

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic             epoch_q, epoch_d;
  logic             trap_q, trap_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] tag_rd_q, tag_rd_d;
  logic [PTR_W-1:0] tag_wr_q, tag_wr_d;

  logic [31:0] tag_mem       [BUF_DEPTH];
  logic [31:0] buf_pc_mem    [BUF_DEPTH];
  logic [31:0] buf_instr_mem [BUF_DEPTH];
  logic        buf_epoch_mem [BUF_DEPTH];

  logic [31:0]  target_pc;
  logic         target_misaligned;
  logic         pop, push, accept, resp_take, resp_drop;
  logic [CNT_W:0] in_use;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign target_pc         = redirect_pc;
  assign target_misaligned = |redirect_pc[1:0];
  assign fetch_misaligned  = trap_q;
`else
  logic unused_redirect_lsbs;
  assign target_pc            = {redirect_pc[31:2], 2'b00};
  assign target_misaligned    = 1'b0;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];
`endif

  // Handshakes and outputs. A slot freed by this cycle's pop is reusable at once,
  // which is what sustains one fetch per cycle with a two-entry budget.
  always_comb begin
    if_valid       = !reset && (occ_q != '0) && !trap_q;
    pop            = if_valid && !stall && !redirect_valid;
    in_use         = (CNT_W + 1)'(outstanding_q) + (CNT_W + 1)'(occ_q) - (CNT_W + 1)'(pop);
    imem_req_valid = !reset && !redirect_valid && !trap_q && (in_use < CAP);
    imem_req_addr  = pc_q;
    accept         = imem_req_valid && imem_req_ready;
    resp_take      = imem_resp_valid && (outstanding_q != '0);
    resp_drop      = resp_take && (state_q == DRAIN);
    push           = resp_take && !resp_drop && !redirect_valid;
    if_packet      = '0;
    if (if_valid) begin
      if_packet = {buf_pc_mem[rd_ptr_q], buf_pc_mem[rd_ptr_q] + 32'd4,
                   buf_instr_mem[rd_ptr_q], buf_epoch_mem[rd_ptr_q]};
    end
  end

  // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    pc_d          = pc_q;
    epoch_d       = epoch_q;
    trap_d        = trap_q;
    outstanding_d = outstanding_q + CNT_W'(accept) - CNT_W'(resp_take);
    drop_cnt_d    = drop_cnt_q;
    occ_d         = occ_q + CNT_W'(push) - CNT_W'(pop);
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    tag_rd_d      = tag_rd_q;
    tag_wr_d      = tag_wr_q;

    if (accept) begin
      pc_d     = pc_q + 32'd4;
      tag_wr_d = tag_wr_q + PTR_W'(1);
    end
    if (resp_take) tag_rd_d   = tag_rd_q + PTR_W'(1);
    if (resp_drop) drop_cnt_d = drop_cnt_q - CNT_W'(1);
    if (push)      wr_ptr_d   = wr_ptr_q + PTR_W'(1);
    if (pop)       rd_ptr_d   = rd_ptr_q + PTR_W'(1);

    // Everything still in flight after this cycle belongs to the old path.
    if (redirect_valid) begin
      pc_d       = target_pc;
      epoch_d    = ~epoch_q;
      trap_d     = target_misaligned;
      drop_cnt_d = outstanding_d;
      occ_d      = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end

    state_d = (drop_cnt_d != '0) ? DRAIN : RUN;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RUN;
      pc_q          <= RESET_PC;
      epoch_q       <= 1'b0;
      trap_q        <= 1'b0;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      occ_q         <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      tag_rd_q      <= '0;
      tag_wr_q      <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      epoch_q       <= epoch_d;
      trap_q        <= trap_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      occ_q         <= occ_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      tag_rd_q      <= tag_rd_d;
      tag_wr_q      <= tag_wr_d;
    end
  end

  // NOTE: storage arrays carry no reset; the occupancy counters and pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (accept) tag_mem[tag_wr_q] <= pc_q;
    if (push) begin
      buf_pc_mem[wr_ptr_q]    <= tag_mem[tag_rd_q];
      buf_instr_mem[wr_ptr_q] <= imem_resp_data;
      buf_epoch_mem[wr_ptr_q] <= epoch_q;
    end
  end

endmodule
